// File: rtl/shared_bus_xfer.sv
// Moves a fixed-length burst from the arbiter-granted client onto one shared
// valid/ready output channel, with done/abort/err status pulses.
module shared_bus_xfer #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              G0,
    input  logic              G1,
    input  logic              V0,
    input  logic              V1,
    input  logic [DATA_W-1:0] D0,
    input  logic [DATA_W-1:0] D1,
    output logic              RDY0,
    output logic              RDY1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              owner,
    output logic              done,
    output logic              abort,
    output logic              err
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;
    logic              done_reg, done_next;
    logic              abort_reg, abort_next;
    logic              err_reg, err_next;

    logic [1:0]        grant_vec, valid_vec, rdy_vec;
    logic              can_load, accept, own_grant, last_beat;
    logic [DATA_W-1:0] own_data;

    assign grant_vec = {G1, G0};
    assign valid_vec = {V1, V0};
    assign can_load  = !out_valid_reg || out_ready;
    assign own_grant = grant_vec[owner_reg];
    assign own_data  = owner_reg ? D1 : D0;
    assign last_beat = (cnt_reg == CNT_W'(BURST_LEN - 1));

    // Ready is gated by the live grant, so a dropped grant never accepts a beat.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdy
            assign rdy_vec[gi] = (state_reg == XFER) && (owner_reg == 1'(gi))
                                 && grant_vec[gi] && can_load;
        end
    endgenerate

    assign accept = |(rdy_vec & valid_vec);

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        abort_next = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (G0 ^ G1) begin
                    owner_next = G1;
                    cnt_next   = '0;
                    state_next = XFER;
                end else if (G0 && G1) begin
                    err_next = 1'b1;
                end
            end
            XFER: begin
                if (!own_grant) begin
                    abort_next = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (accept) begin
                    if (last_beat) begin
                        done_next  = 1'b1;
                        cnt_next   = '0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            abort_reg <= abort_next;
            err_reg   <= err_next;
        end
    end

    // Output register drains independently of the burst state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_data_reg  <= own_data;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign RDY0      = rdy_vec[0];
    assign RDY1      = rdy_vec[1];
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == XFER) || (state_reg == DONE);
    assign owner     = owner_reg;
    assign done      = done_reg;
    assign abort     = abort_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_shared_bus_xfer.sv
// Directed bench for shared_bus_xfer: bursts, backpressure, valid gaps,
// abort, grant fault and asynchronous reset mid-burst.
module tb_shared_bus_xfer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       G0 = 1'b0, G1 = 1'b0, V0 = 1'b0, V1 = 1'b0;
    logic [7:0] D0 = 8'h00, D1 = 8'h00;
    logic       RDY0, RDY1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy, owner, done, abort, err;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] rx_q[$];

    shared_bus_xfer #(.DATA_W(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .G0(G0), .G1(G1), .V0(V0), .V1(V1), .D0(D0), .D1(D1),
        .RDY0(RDY0), .RDY1(RDY1),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .owner(owner), .done(done), .abort(abort), .err(err)
    );

    always #5 clk = ~clk;

    // Words that actually leave on the output channel.
    always @(posedge clk)
        if (rst_n && out_valid && out_ready) rx_q.push_back(out_data);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit c, input logic g, input logic v, input logic [7:0] d);
        if (c) begin G1 = g; V1 = v; D1 = d; end
        else   begin G0 = g; V0 = v; D0 = d; end
    endtask

    task automatic check_rx(input string tag, input logic [7:0] base, input int n);
        check({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check({tag, "_word"}, rx_q[i], base + 8'(i));
    endtask

    task automatic do_burst(input bit c, input logic [7:0] base);
        rx_q.delete();
        out_ready = 1'b1;
        drive(c, 1'b1, 1'b1, base);
        step();
        check("burst_rdy", c ? RDY1 : RDY0, 1'b1);
        check("burst_owner", owner, c);
        check("burst_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(c, 1'b1, 1'b1, base + 8'(i));
            step();
            check("burst_data", out_data, base + 8'(i));
            check("burst_done", done, i == 3);
        end
        drive(c, 1'b0, 1'b0, 8'h00);
        check("burst_busy_done", busy, 1'b1);
        step();
        check("burst_busy_end", busy, 1'b0);
        check("burst_done_end", done, 1'b0);
        check_rx("burst_rx", base, 4);
        $display("burst client=%0d base=%0h words=%0d", c, base, rx_q.size());
    endtask

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_pulses", {done, abort, err}, 3'b000);
        check("rst_rdy", {RDY1, RDY0}, 2'b00);
        step();
        rst_n = 1'b1;

        // Basic burst, client 0
        do_burst(1'b0, 8'h10);

        // Backpressure, client 1
        rx_q.delete();
        out_ready = 1'b1;
        G1 = 1'b1; V1 = 1'b1; D1 = 8'h20;
        step();
        check("bp_owner", owner, 1'b1);
        check("bp_rdy_first", RDY1, 1'b1);
        out_ready = 1'b0;
        step();
        D1 = 8'h21;
        for (int k = 0; k < 3; k++) begin
            check("bp_rdy_low", RDY1, 1'b0);
            check("bp_hold", out_data, 8'h20);
            check("bp_valid", out_valid, 1'b1);
            if (k < 2) step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_resume", RDY1, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step();
            check("bp_data", out_data, 8'h20 + 8'(i));
            check("bp_done", done, i == 3);
            D1 = 8'h21 + 8'(i);
        end
        G1 = 1'b0; V1 = 1'b0;
        step();
        check_rx("bp_rx", 8'h20, 4);
        $display("burst client=1 backpressure words=%0d", rx_q.size());

        // Valid gaps, client 1
        rx_q.delete();
        begin
            int beats;
            beats = 0;
            G1 = 1'b1; V1 = 1'b0; D1 = 8'h30;
            step();
            for (int k = 0; k < 7; k++) begin
                V1 = (k % 2 == 0);
                D1 = 8'h30 + 8'(beats);
                step();
                if (V1) beats++;
                check("gap_valid", out_valid, V1);
                if (V1) check("gap_data", out_data, 8'h30 + 8'(beats - 1));
                check("gap_done", done, k == 6);
            end
            G1 = 1'b0; V1 = 1'b0;
            step();
            check_rx("gap_rx", 8'h30, 4);
            $display("burst client=1 gaps beats=%0d", beats);
        end

        // Grant fault in IDLE
        G0 = 1'b1; G1 = 1'b1;
        step();
        check("fault_err", err, 1'b1);
        check("fault_rdy", {RDY1, RDY0}, 2'b00);
        check("fault_busy", busy, 1'b0);
        check("fault_owner", owner, 1'b1);
        G0 = 1'b0; G1 = 1'b0;
        step();
        check("fault_err_clr", err, 1'b0);
        check("fault_idle", busy, 1'b0);
        $display("grant fault err observed");

        // Abort after two beats, client 0
        rx_q.delete();
        G0 = 1'b1; V0 = 1'b1; D0 = 8'h40;
        step();
        step();
        D0 = 8'h41;
        step();
        check("abort_data2", out_data, 8'h41);
        G0 = 1'b0;
        #1;
        check("abort_rdy", RDY0, 1'b0);
        step();
        check("abort_pulse", abort, 1'b1);
        check("abort_no_done", done, 1'b0);
        check("abort_idle", busy, 1'b0);
        V0 = 1'b0;
        step();
        check("abort_clr", abort, 1'b0);
        check_rx("abort_rx", 8'h40, 2);
        $display("burst client=0 aborted words=%0d", rx_q.size());
        do_burst(1'b0, 8'h50);

        // Asynchronous reset mid-burst, client 1
        rx_q.delete();
        G1 = 1'b1; V1 = 1'b1; D1 = 8'h60;
        step();
        step();
        check("mid_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_out_data", out_data, 8'h00);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_owner", owner, 1'b0);
        check("mid_rdy", {RDY1, RDY0}, 2'b00);
        check("mid_pulses", {done, abort, err}, 3'b000);
        G1 = 1'b0; V1 = 1'b0;
        step();
        rst_n = 1'b1;
        check_rx("mid_rx", 8'h60, 0);
        $display("reset mid-burst discarded words=%0d", rx_q.size());
        do_burst(1'b1, 8'h70);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
